// File: rtl/mux_sel_sequencer.sv
// Select-tree mux scanner: walks enabled channels, samples the mux output
// after a settle time, and hands the packed word downstream via valid/ready.
module mux_sel_sequencer #(
   parameter int SEL_W      = 2,
   parameter int SETTLE_CYC = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic [(1<<SEL_W)-1:0] ch_en_i,
   output logic [SEL_W-1:0]      sel_o,
   input  logic                  mux_i,
   output logic [(1<<SEL_W)-1:0] data_o,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic                  busy_o
);

   localparam int NCH = 1 << SEL_W;
   localparam int CW  = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
   localparam logic [CW-1:0] SETTLE = CW'(SETTLE_CYC);

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [NCH-1:0]   mask_q, mask_d;
   logic [NCH-1:0]   shadow_q, shadow_d;
   logic [NCH-1:0]   data_q, data_d;
   logic             valid_q, valid_d;

   logic [SEL_W-1:0] first_sel;
   logic [SEL_W-1:0] nxt_sel;
   logic             has_nxt;

   // Lowest enabled channel in the incoming mask.
   always_comb begin
      first_sel = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (ch_en_i[i]) first_sel = SEL_W'(i);
      end
   end

   // Lowest enabled channel strictly above the current select.
   always_comb begin
      has_nxt = 1'b0;
      nxt_sel = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (mask_q[i] && (i > int'(sel_q))) begin
            has_nxt = 1'b1;
            nxt_sel = SEL_W'(i);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      cnt_d    = cnt_q;
      mask_d   = mask_q;
      shadow_d = shadow_q;
      data_d   = data_q;
      valid_d  = valid_q;
      unique case (state_q)
         IDLE: begin
            sel_d = '0;
            if (start_i) begin
               mask_d   = ch_en_i;
               shadow_d = '0;
               if (|ch_en_i) begin
                  state_d = SCAN;
                  sel_d   = first_sel;
                  cnt_d   = SETTLE;
               end else begin
                  state_d = DONE;
                  data_d  = '0;
                  valid_d = 1'b1;
               end
            end
         end
         SCAN: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CW'(1);
            end else begin
               shadow_d[sel_q] = mux_i;
               if (has_nxt) begin
                  sel_d = nxt_sel;
                  cnt_d = SETTLE;
               end else begin
                  data_d  = shadow_d;
                  valid_d = 1'b1;
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (ready_i) begin
               valid_d = 1'b0;
               sel_d   = '0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         sel_q    <= '0;
         cnt_q    <= '0;
         mask_q   <= '0;
         shadow_q <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         cnt_q    <= cnt_d;
         mask_q   <= mask_d;
         shadow_q <= shadow_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
      end
   end

   assign sel_o   = sel_q;
   assign data_o  = data_q;
   assign valid_o = valid_q;
   assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Bench for mux_sel_sequencer: two instances (settle 1 and settle 0)
// checked against a per-transaction timing/data model.
module tb_mux_sel_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       start [2];
   logic [3:0] ch_en [2];
   logic       mux   [2];
   logic [1:0] sel   [2];
   logic [3:0] data  [2];
   logic       valid [2];
   logic       ready [2];
   logic       busy  [2];
   logic [3:0] pat   [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign mux[0] = pat[0][sel[0]];
   assign mux[1] = pat[1][sel[1]];

   mux_sel_sequencer #(.SEL_W(2), .SETTLE_CYC(1)) dut0 (
      .clk(clk), .rst(rst), .start_i(start[0]), .ch_en_i(ch_en[0]),
      .sel_o(sel[0]), .mux_i(mux[0]), .data_o(data[0]),
      .valid_o(valid[0]), .ready_i(ready[0]), .busy_o(busy[0])
   );

   mux_sel_sequencer #(.SEL_W(2), .SETTLE_CYC(0)) dut1 (
      .clk(clk), .rst(rst), .start_i(start[1]), .ch_en_i(ch_en[1]),
      .sel_o(sel[1]), .mux_i(mux[1]), .data_o(data[1]),
      .valid_o(valid[1]), .ready_i(ready[1]), .busy_o(busy[1])
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic chk_idle(input int k, input string tag);
      chk({tag, "_valid"}, 32'(valid[k]), 32'd0);
      chk({tag, "_busy"}, 32'(busy[k]), 32'd0);
      chk({tag, "_sel"}, 32'(sel[k]), 32'd0);
   endtask

   // One scan transaction; called at a negedge with the DUT idle.
   task automatic run(input int k, input logic [3:0] m,
                      input logic [3:0] p, input int rdly);
      int s;
      int en[$];
      int e;
      int lat;
      int last;
      logic [3:0] exp_d;
      s = (k == 0) ? 1 : 0;
      for (int i = 0; i < 4; i++) if (m[i]) en.push_back(i);
      e     = en.size();
      lat   = 1 + e * (s + 1);
      exp_d = m & p;
      last  = (e > 0) ? en[e-1] : 0;
      pat[k]   = p;
      ch_en[k] = m;
      start[k] = 1'b1;
      ready[k] = (rdly == 0);
      @(posedge clk);
      #1;
      start[k] = 1'b0;
      ch_en[k] = 4'($urandom);
      for (int t = 1; t <= lat; t++) begin
         @(negedge clk);
         if (t < lat) begin
            chk("scan_sel", 32'(sel[k]), 32'(en[(t-1)/(s+1)]));
            chk("scan_valid", 32'(valid[k]), 32'd0);
            chk("scan_busy", 32'(busy[k]), 32'd1);
         end else begin
            chk("done_valid", 32'(valid[k]), 32'd1);
            chk("done_data", 32'(data[k]), 32'(exp_d));
            chk("done_sel", 32'(sel[k]), 32'(last));
            chk("done_busy", 32'(busy[k]), 32'd1);
         end
      end
      for (int r = 0; r < rdly; r++) begin
         start[k] = (r % 2 == 0);
         @(negedge clk);
         chk("hold_valid", 32'(valid[k]), 32'd1);
         chk("hold_data", 32'(data[k]), 32'(exp_d));
         chk("hold_sel", 32'(sel[k]), 32'(last));
      end
      ready[k] = 1'b1;
      start[k] = 1'b1;
      @(negedge clk);
      start[k] = 1'b0;
      chk_idle(k, "post");
      ready[k] = 1'($urandom);
   endtask

   initial begin
      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         start[k] = 1'b0;
         ch_en[k] = '0;
         ready[k] = 1'b0;
         pat[k]   = '0;
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk_idle(k, "rst");
         chk("rst_data", 32'(data[k]), 32'd0);
      end
      rst = 1'b0;
      @(negedge clk);

      run(0, 4'b1111, 4'b1010, 0);
      run(0, 4'b0101, 4'b1111, 0);
      run(0, 4'b0000, 4'b1111, 0);
      run(0, 4'b1011, 4'b0110, 5);
      run(1, 4'b1111, 4'b0101, 0);
      run(1, 4'b0000, 4'b0000, 2);

      // Reset in the middle of a scan.
      pat[0]   = 4'b1010;
      ch_en[0] = 4'b1111;
      start[0] = 1'b1;
      ready[0] = 1'b1;
      @(posedge clk);
      #1;
      start[0] = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_idle(0, "midrst");
      chk("midrst_data", 32'(data[0]), 32'd0);
      rst = 1'b0;
      run(0, 4'b1111, 4'b1010, 0);

      for (int n = 0; n < 40; n++) begin
         run(int'($urandom_range(0, 1)), 4'($urandom), 4'($urandom),
             int'($urandom_range(0, 3)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
